// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
// Contents:
//   state_e  - controller state encoding
//   off_w    - byte offset width within a line
//   wsel_w   - word-select width within a line
//   idx_w    - set index width
//   tag_w    - tag width
//   ptr_w    - round-robin pointer width (kept at least 1 bit wide)
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2,
        S_REFILL    = 2'd3
    } state_e;

    function automatic int off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int wsel_w(input int line_w, input int word_w);
        return $clog2(line_w / word_w);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int line_w, input int sets);
        return addr_w - off_w(line_w) - idx_w(sets);
    endfunction

    function automatic int ptr_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/dcache_sa_way.sv
// One way of the data cache: valid/dirty bits, tag and line storage for
// every set, plus tag compare and word-granular read/write.
// Ports:
//   clk_i, rst_i        clock, async active-high reset (clears valid/dirty)
//   idx_i, tag_i        set index and tag of the current request
//   wsel_i              word select within the line
//   hit_o               valid entry with matching tag at idx_i
//   valid_o, dirty_o    state bits of the entry at idx_i
//   tag_o, line_o       stored tag and line at idx_i (victim writeback)
//   word_o              selected word of the line at idx_i
//   wr_word_en_i/_i     store one word at idx_i/wsel_i and mark dirty
//   fill_en_i, fill_*   install a whole line: valid=1, dirty=0, new tag
module dcache_sa_way
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int IDX_W  = idx_w(SETS),
    parameter int WSEL_W = wsel_w(LINE_W, WORD_W),
    parameter int TAG_W  = tag_w(ADDR_W, LINE_W, SETS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [WSEL_W-1:0] wsel_i,
    output logic              hit_o,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    output logic [WORD_W-1:0] word_o,
    input  logic              wr_word_en_i,
    input  logic [WORD_W-1:0] wr_word_i,
    input  logic              fill_en_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0] fill_line_i
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (wr_word_en_i) begin
            dirty_q[idx_i] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (wr_word_en_i) begin
            data_q[idx_i][wsel_i*WORD_W +: WORD_W] <= wr_word_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];
    assign word_o  = line_o[wsel_i*WORD_W +: WORD_W];
    assign hit_o   = valid_o && (tag_o == tag_i);

endmodule

// File: rtl/dcache_sa.sv
// Set-associative, write-back, write-allocate data cache between the
// pipeline memory stage and a line-wide data memory.
// Ports:
//   clk_i, rst_i       clock, async active-high reset
//   p1_addr_i          CPU byte address (word aligned)
//   p1_data_i          store data
//   p1_MemRead_i/Write load/store request (both high = store)
//   p1_data_o          load data of the hitting way, 0 when no hit
//   p1_stall_o         pipeline freeze
//   mem_addr_o         line-aligned memory address (registered)
//   mem_data_o         writeback line (registered)
//   mem_enable_o       memory request (registered)
//   mem_write_o        1 = write, 0 = read (registered)
//   mem_data_i         refill line
//   mem_ack_i          one-cycle completion pulse
//   miss_cnt_o         saturating miss count
//   wb_cnt_o           saturating writeback count
//
// state       | meaning
// S_IDLE      | serve hits; on miss pick victim and launch memory request
// S_WRITEBACK | write dirty victim line, wait for ack
// S_ALLOCATE  | read requested line, wait for ack and capture it
// S_REFILL    | install captured line into victim way, advance pointer
module dcache_sa
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  miss_cnt_o,
    output logic [CNT_W-1:0]  wb_cnt_o
);

    localparam int OFF_W  = off_w(LINE_W);
    localparam int WSEL_W = wsel_w(LINE_W, WORD_W);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
    localparam int PTR_W  = ptr_w(WAYS);
    localparam int BYTE_W = OFF_W - WSEL_W;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [WSEL_W-1:0] req_wsel;
    logic              req;
    logic              unused_byte;

    assign req_idx     = p1_addr_i[OFF_W +: IDX_W];
    assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign req_wsel    = p1_addr_i[BYTE_W +: WSEL_W];
    assign req         = p1_MemRead_i | p1_MemWrite_i;
    assign unused_byte = ^p1_addr_i[BYTE_W-1:0];

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  victim_q, victim_d;
    logic [LINE_W-1:0] fill_q, fill_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_data_q, mem_data_d;
    logic [CNT_W-1:0]  miss_cnt_q, wb_cnt_q;
    logic              miss_inc, wb_inc, fill_en, store_hit, stall;

    logic [WAYS-1:0]   way_hit, way_valid, way_dirty;
    logic [TAG_W-1:0]  way_tag  [WAYS];
    logic [LINE_W-1:0] way_line [WAYS];
    logic [WORD_W-1:0] way_word [WAYS];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        dcache_sa_way #(
            .ADDR_W(ADDR_W),
            .WORD_W(WORD_W),
            .LINE_W(LINE_W),
            .SETS  (SETS)
        ) u_way (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .idx_i       (req_idx),
            .tag_i       (req_tag),
            .wsel_i      (req_wsel),
            .hit_o       (way_hit[w]),
            .valid_o     (way_valid[w]),
            .dirty_o     (way_dirty[w]),
            .tag_o       (way_tag[w]),
            .line_o      (way_line[w]),
            .word_o      (way_word[w]),
            .wr_word_en_i(store_hit && way_hit[w]),
            .wr_word_i   (p1_data_i),
            .fill_en_i   (fill_en && (victim_q == PTR_W'(w))),
            .fill_tag_i  (req_tag),
            .fill_line_i (fill_q)
        );
    end

    // Round-robin pointer per set; direct-mapped needs no storage.
    logic [PTR_W-1:0] ptr_cur;

    if (WAYS > 1) begin : g_ptr
        logic [PTR_W-1:0] ptr_q [SETS];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int s = 0; s < SETS; s++) begin
                    ptr_q[s] <= '0;
                end
            end else if (state_q == S_REFILL && victim_q == ptr_q[req_idx]) begin
                ptr_q[req_idx] <= (ptr_q[req_idx] == PTR_W'(WAYS - 1)) ? '0
                                                                       : ptr_q[req_idx] + 1'b1;
            end
        end

        assign ptr_cur = ptr_q[req_idx];
    end else begin : g_noptr
        assign ptr_cur = '0;
    end

    logic              hit_any;
    logic [WORD_W-1:0] hit_word;
    logic [PTR_W-1:0]  vic_sel;

    assign hit_any = |way_hit;

    always_comb begin
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_word = hit_word | way_word[w];
        end
    end

    // Lowest-numbered invalid way wins; otherwise the set's pointer way.
    always_comb begin
        vic_sel = ptr_cur;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) vic_sel = PTR_W'(w);
        end
    end

    always_comb begin
        state_d    = state_q;
        victim_d   = victim_q;
        fill_d     = fill_q;
        mem_en_d   = mem_en_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        miss_inc   = 1'b0;
        wb_inc     = 1'b0;
        fill_en    = 1'b0;
        store_hit  = 1'b0;
        stall      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit_any) begin
                        store_hit = p1_MemWrite_i;
                    end else begin
                        stall    = 1'b1;
                        miss_inc = 1'b1;
                        victim_d = vic_sel;
                        mem_en_d = 1'b1;
                        if (way_valid[vic_sel] && way_dirty[vic_sel]) begin
                            state_d    = S_WRITEBACK;
                            wb_inc     = 1'b1;
                            mem_wr_d   = 1'b1;
                            mem_addr_d = {way_tag[vic_sel], req_idx, {OFF_W{1'b0}}};
                            mem_data_d = way_line[vic_sel];
                        end else begin
                            state_d    = S_ALLOCATE;
                            mem_wr_d   = 1'b0;
                            mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
                        end
                    end
                end
            end
            S_WRITEBACK: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    // Enable stays high straight into the read.
                    state_d    = S_ALLOCATE;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = {req_tag, req_idx, {OFF_W{1'b0}}};
                end
            end
            S_ALLOCATE: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    state_d  = S_REFILL;
                    fill_d   = mem_data_i;
                    mem_en_d = 1'b0;
                end
            end
            S_REFILL: begin
                stall   = 1'b1;
                fill_en = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            victim_q   <= '0;
            fill_q     <= '0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            fill_q     <= fill_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            if (miss_inc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            if (wb_inc && wb_cnt_q != '1)     wb_cnt_q   <= wb_cnt_q + 1'b1;
        end
    end

    assign p1_data_o    = hit_word;
    assign p1_stall_o   = stall;
    assign mem_enable_o = mem_en_q;
    assign mem_write_o  = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign miss_cnt_o   = miss_cnt_q;
    assign wb_cnt_o     = wb_cnt_q;

endmodule

// File: tb/tb_dcache_sa.sv
// Directed bench for dcache_sa. Memory answers every request with an ack in
// the third cycle of mem_enable_o; unwritten lines hold word k of line A = A+4k.
module tb_dcache_sa;

    localparam int CNT_W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  p1_addr = '0;
    logic [31:0]  p1_wdata = '0;
    logic         p1_rd = 1'b0;
    logic         p1_wr = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic [CNT_W-1:0] miss_cnt_o;
    logic [CNT_W-1:0] wb_cnt_o;

    always #5 clk = ~clk;

    dcache_sa #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p1_addr_i    (p1_addr),
        .p1_data_i    (p1_wdata),
        .p1_MemRead_i (p1_rd),
        .p1_MemWrite_i(p1_wr),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .miss_cnt_o   (miss_cnt_o),
        .wb_cnt_o     (wb_cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [255:0] mem [logic [31:0]];
    int           lat_cnt = 0;
    int           tx_total = 0;
    logic [31:0]  tx_addr [64];
    logic         tx_wr   [64];

    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = a + 32'(4 * k);
        return l;
    endfunction

    always @(negedge clk) begin
        if (mem_enable_o) begin
            lat_cnt++;
            if (lat_cnt == 3) begin
                lat_cnt   = 0;
                mem_ack_i = 1'b1;
                tx_addr[tx_total % 64] = mem_addr_o;
                tx_wr[tx_total % 64]   = mem_write_o;
                tx_total++;
                if (mem_write_o) mem[mem_addr_o] = mem_data_o;
                else mem_data_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : pat(mem_addr_o);
            end else begin
                mem_ack_i = 1'b0;
            end
        end else begin
            lat_cnt   = 0;
            mem_ack_i = 1'b0;
        end
    end

    // ---------------- access helpers ----------------
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic rd,
                          input logic wr, output int st, output int en_c, output int wr_c,
                          output logic [31:0] rdata);
        @(posedge clk); #1;
        p1_addr = a; p1_wdata = d; p1_rd = rd; p1_wr = wr;
        st = 0; en_c = 0; wr_c = 0;
        @(negedge clk);
        while (p1_stall_o === 1'b1 && st < 40) begin
            st++;
            if (mem_enable_o) en_c++;
            if (mem_write_o) wr_c++;
            @(negedge clk);
        end
        rdata = p1_data_o;
        @(posedge clk); #1;
        p1_rd = 1'b0; p1_wr = 1'b0;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic rd, input logic wr, input int exp_st, input int exp_en,
                       input int exp_wrc, input logic [31:0] exp_data);
        int st, en_c, wr_c;
        logic [31:0] rdata;
        access(a, d, rd, wr, st, en_c, wr_c, rdata);
        check({tag, "_stall"}, 64'(st), 64'(exp_st));
        check({tag, "_en_cyc"}, 64'(en_c), 64'(exp_en));
        check({tag, "_wr_cyc"}, 64'(wr_c), 64'(exp_wrc));
        check({tag, "_data"}, 64'(rdata), 64'(exp_data));
    endtask

    task automatic check_tx(input string tag, input int idx, input logic [31:0] a, input logic w);
        check({tag, "_addr"}, 64'(tx_addr[idx % 64]), 64'(a));
        check({tag, "_wr"}, 64'(tx_wr[idx % 64]), 64'(w));
    endtask

    int base;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_stall", 64'(p1_stall_o), 64'(0));
        check("rst_en", 64'(mem_enable_o), 64'(0));
        check("rst_wr", 64'(mem_write_o), 64'(0));
        check("rst_addr", 64'(mem_addr_o), 64'(0));
        check("rst_mdata_nz", 64'(|mem_data_o), 64'(0));
        check("rst_rdata", 64'(p1_data_o), 64'(0));
        check("rst_miss", 64'(miss_cnt_o), 64'(0));
        check("rst_wb", 64'(wb_cnt_o), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // cold load miss: detect + 3 allocate + refill
        base = tx_total;
        run("ld100", 32'h100, 32'h0, 1'b1, 1'b0, 5, 3, 0, 32'h100);
        check("ld100_ntx", 64'(tx_total - base), 64'(1));
        check_tx("ld100_tx", base, 32'h100, 1'b0);
        check("ld100_miss", 64'(miss_cnt_o), 64'(1));

        run("ld104", 32'h104, 32'h0, 1'b1, 1'b0, 0, 0, 0, 32'h104);

        // read+write together is a store; data out shows the old word
        base = tx_total;
        run("rw100", 32'h100, 32'h1111_2222, 1'b1, 1'b1, 0, 0, 0, 32'h100);
        run("ld100b", 32'h100, 32'h0, 1'b1, 1'b0, 0, 0, 0, 32'h1111_2222);
        check("rw_ntx", 64'(tx_total - base), 64'(0));

        // set 8: way1 free, so clean miss
        run("st500", 32'h500, 32'hDEAD_BEEF, 1'b0, 1'b1, 5, 3, 0, 32'h500);
        check("st500_miss", 64'(miss_cnt_o), 64'(2));

        // pointer at way0 (dirty 0x100): writeback then allocate
        base = tx_total;
        run("st900", 32'h900, 32'h9999_9999, 1'b0, 1'b1, 8, 6, 3, 32'h900);
        check_tx("st900_wb", base, 32'h100, 1'b1);
        check_tx("st900_rd", base + 1, 32'h900, 1'b0);
        check("st900_wbcnt", 64'(wb_cnt_o), 64'(1));

        // pointer at way1 (dirty 0x500)
        base = tx_total;
        run("stD00", 32'hD00, 32'hDDDD_0000, 1'b0, 1'b1, 8, 6, 3, 32'hD00);
        check_tx("stD00_wb", base, 32'h500, 1'b1);
        check_tx("stD00_rd", base + 1, 32'hD00, 1'b0);
        check("stD00_wbcnt", 64'(wb_cnt_o), 64'(2));
        check("stD00_miss", 64'(miss_cnt_o), 64'(4));

        // pointer back at way0 (dirty 0x900); 0x500 returns from memory
        base = tx_total;
        run("ld500", 32'h500, 32'h0, 1'b1, 1'b0, 8, 6, 3, 32'hDEAD_BEEF);
        check_tx("ld500_wb", base, 32'h900, 1'b1);

        base = tx_total;
        run("ld100c", 32'h100, 32'h0, 1'b1, 1'b0, 8, 6, 3, 32'h1111_2222);
        check_tx("ld100c_wb", base, 32'hD00, 1'b1);
        check("ld100c_miss", 64'(miss_cnt_o), 64'(6));
        check("ld100c_wbcnt", 64'(wb_cnt_o), 64'(4));

        // reset in the middle of an allocate
        @(posedge clk); #1;
        p1_addr = 32'h2000; p1_rd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("alloc_en", 64'(mem_enable_o), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("rstmid_en", 64'(mem_enable_o), 64'(0));
        check("rstmid_miss", 64'(miss_cnt_o), 64'(0));
        check("rstmid_wb", 64'(wb_cnt_o), 64'(0));
        p1_rd = 1'b0;
        #1;
        check("rstmid_stall", 64'(p1_stall_o), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        base = tx_total;
        run("post_rst", 32'h100, 32'h0, 1'b1, 1'b0, 5, 3, 0, 32'h1111_2222);
        check_tx("post_rst_rd", base, 32'h100, 1'b0);
        check("post_rst_miss", 64'(miss_cnt_o), 64'(1));

        // hammer set 2 with distinct tags to saturate both counters
        for (int k = 0; k < 70; k++) begin
            run("sat", (32'(k) << 10) | 32'h40, 32'(k), 1'b0, 1'b1,
                (k < 2) ? 5 : 8, (k < 2) ? 3 : 6, (k < 2) ? 0 : 3, (32'(k) << 10) | 32'h40);
            if (k == 9) begin
                check("sat_mid_miss", 64'(miss_cnt_o), 64'(11));
                check("sat_mid_wb", 64'(wb_cnt_o), 64'(8));
            end
        end
        check("sat_miss", 64'(miss_cnt_o), 64'(63));
        check("sat_wb", 64'(wb_cnt_o), 64'(63));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
